scoreboard: RTL
===============

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 instr  input  32  instruction presented at decode input.
REQ-004 valid  input  1  instr is valid this cycle.
REQ-005 issue  input  1  decode captures instr into its output register this cycle (valid && ready && !jmp).
REQ-006 wb_en  input  1  register-file write retiring this cycle.
REQ-007 wb_reg  input  5  destination of retiring write.
REQ-008 cancel_en  input  1  an issued instruction was squashed; its write will never occur.
REQ-009 cancel_reg  input  5  destination of squashed instruction.
REQ-010 stall  output  1  hazard on presented instr; drives the decode stall input.
REQ-011 pending  output  32  bit n = register n has at least one outstanding write.
REQ-012 sb_err  output  1  sticky error flag: release seen for a register with zero count.

Function
REQ-013 Per register 1..31, a 2-bit pending-write counter; x0 is never tracked, and pending[0] = 0 always.
REQ-014 Writes rd: opcodes LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD, only when rd != 0.
REQ-015 Reads rs1: all opcodes except LUI, AUIPC, JAL. Reads rs2: OP, STORE, BRANCH only.
REQ-016 stall is combinational: valid && (rs1 counter != 0 || rs2 counter != 0 || rd counter == 3); stall = 0 when valid = 0.
REQ-017 issue with a writing instr increments counter[rd] at the clock edge; issue is ignored when stall = 1 (upstream guarantees this never happens; assertion).
REQ-018 wb_en decrements counter[wb_reg]; cancel_en decrements counter[cancel_reg]; wb_reg = 0 and cancel_reg = 0 are ignored.
REQ-019 Simultaneous increment and one decrement on the same register: net unchanged. Simultaneous wb and cancel on the same register: decrement by 2.
REQ-020 A decrement at count 0 leaves count 0 and sets sb_err; counters never wrap.
REQ-021 Latency: an issue is visible on stall/pending the next cycle. A release clears the hazard the next cycle; there is no same-cycle release-to-stall path (register-file write is registered).
REQ-022 jmp has no direct effect; squashed issues are reported only through cancel_en.

Reset
REQ-023 On rst: all counters 0, pending = 0, sb_err = 0, stall = 0 regardless of instr. rst overrides same-cycle issue/wb/cancel.
REQ-024 rst mid-operation discards all outstanding entries; the surrounding pipeline is reset in the same cycle.

Configuration
REQ-025 Macro SCOREBOARD_STATS_EN. When defined: output stall_cycles (32 bit) counts cycles with stall = 1, reset to 0, saturating at 32'hFFFFFFFF. When undefined: the port and counter are absent.

Structure
REQ-026 Opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP) belong in the shared cpu header package alongside the ALU op codes.
REQ-027 Field/usage decode is one combinational sub-module, instr_regs_decode: instr -> rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd.

Verification
REQ-028 Issue ADDI x5,x0,1, then present ADD x6,x5,x5 next cycle -> stall = 1, pending[5] = 1. wb_en, wb_reg = 5 -> stall = 0 the following cycle.
REQ-029 Present LUI x7 with pending[7] = 0 -> stall = 0. Issue three writes to x7 without retire -> fourth LUI x7 -> stall = 1 (count = 3).
REQ-030 Same cycle: issue write x9 and wb_en, wb_reg = 9, starting at count 1 -> count remains 1, pending[9] = 1.
REQ-031 cancel_en, cancel_reg = 10 at count 0 -> sb_err = 1 and stays 1 until rst; pending[10] = 0.
REQ-032 Instr ADDI x0,x1,0 with x1 not pending -> no tracking; SW with rs2 = x5 pending -> stall = 1; BRANCH with rs1 = x0 -> no hazard from x0.
REQ-033 Assert rst with several counters nonzero and issue = 1 -> next cycle pending = 0, stall = 0, sb_err = 0, stall_cycles = 0 (with the stats macro defined).

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared CPU header: base opcodes, ALU op codes and scoreboard types.
// Consumed by the scoreboard top (optional SCOREBOARD_STATS_EN stall counter) and its decoder.
package scoreboard_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   localparam int NUM_REGS = 32;

   typedef logic [1:0] sb_cnt_t;
   localparam sb_cnt_t SB_CNT_MAX = 2'd3;

endpackage

// File: rtl/scoreboard_checker.sv
// Protocol checks for the scoreboard: decode must never issue into a stall.
module scoreboard_checker (
   input logic clk,
   input logic rst,
   input logic issue,
   input logic stall
);

   ap_no_issue_on_stall: assert property (@(posedge clk) disable iff (rst) !(issue && stall));

endmodule

// File: rtl/scoreboard_instr_regs_decode.sv
// Combinational register-field and register-usage decode of one instruction.
// A destination of x0 is reported as not written, so x0 is never tracked.
module instr_regs_decode
   import scoreboard_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        writes_rd
);

   logic [6:0] opcode_s;
   logic       writes_raw_s;
   logic       unused_fields_s;

   assign opcode_s        = instr[6:0];
   assign rd              = instr[11:7];
   assign rs1             = instr[19:15];
   assign rs2             = instr[24:20];
   assign unused_fields_s = ^{instr[31:25], instr[14:12]};

   // Opcode to usage; unknown opcodes read rs1 and write nothing
   always_comb begin
      uses_rs1     = 1'b1;
      uses_rs2     = 1'b0;
      writes_raw_s = 1'b0;
      case (opcode_s)
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            uses_rs1     = 1'b0;
            writes_raw_s = 1'b1;
         end
         OPC_JALR, OPC_OP_IMM, OPC_LOAD: begin
            writes_raw_s = 1'b1;
         end
         OPC_OP: begin
            uses_rs2     = 1'b1;
            writes_raw_s = 1'b1;
         end
         OPC_STORE, OPC_BRANCH: begin
            uses_rs2     = 1'b1;
         end
         default: begin
            uses_rs1     = 1'b1;
         end
      endcase
   end

   assign writes_rd = writes_raw_s && (rd != 5'd0);

endmodule

// File: rtl/scoreboard.sv
// Register write scoreboard: 2-bit outstanding-write counters for x1..x31 with hazard stall.
// Define SCOREBOARD_STATS_EN to add the saturating stall_cycles counter output.
module scoreboard
   import scoreboard_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        valid,
   input  logic        issue,
   input  logic        wb_en,
   input  logic [4:0]  wb_reg,
   input  logic        cancel_en,
   input  logic [4:0]  cancel_reg,
   output logic        stall,
   output logic [31:0] pending,
   output logic        sb_err
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   logic [4:0] rs1_s;
   logic [4:0] rs2_s;
   logic [4:0] rd_s;
   logic       uses_rs1_s;
   logic       uses_rs2_s;
   logic       writes_rd_s;
   logic       hazard_s;
   logic       inc_en_s;
   logic       err_s;
   logic       sb_err_r;
   logic [31:0] pending_r;
   sb_cnt_t    cnt_r     [NUM_REGS];
   sb_cnt_t    cnt_nxt_s [NUM_REGS];

   instr_regs_decode u_decode (
      .instr     (instr),
      .rs1       (rs1_s),
      .rs2       (rs2_s),
      .rd        (rd_s),
      .uses_rs1  (uses_rs1_s),
      .uses_rs2  (uses_rs2_s),
      .writes_rd (writes_rd_s)
   );

   // Hazard from registered counters only; no release-to-stall bypass
   always_comb begin
      hazard_s = (uses_rs1_s && (cnt_r[rs1_s] != 2'd0)) ||
                 (uses_rs2_s && (cnt_r[rs2_s] != 2'd0)) ||
                 (writes_rd_s && (cnt_r[rd_s] == SB_CNT_MAX));
      if (rst) begin
         stall = 1'b0;
      end else begin
         stall = valid && hazard_s;
      end
   end

   assign inc_en_s = issue && !stall && writes_rd_s;

   // Next count per register: +issue, -wb, -cancel, clamped to 0..3
   always_comb begin
      err_s        = 1'b0;
      cnt_nxt_s[0] = 2'd0;
      for (int i = 1; i < NUM_REGS; i++) begin
         logic [2:0] sum_v;
         logic [2:0] dec_v;
         sum_v = {1'b0, cnt_r[i]} + {2'b00, (inc_en_s && (rd_s == 5'(i)))};
         dec_v = {2'b00, (wb_en && (wb_reg == 5'(i)))} +
                 {2'b00, (cancel_en && (cancel_reg == 5'(i)))};
         if (sum_v < dec_v) begin
            cnt_nxt_s[i] = 2'd0;
            err_s        = 1'b1;
         end else if ((sum_v - dec_v) > 3'd3) begin
            cnt_nxt_s[i] = SB_CNT_MAX;
         end else begin
            cnt_nxt_s[i] = 2'(sum_v - dec_v);
         end
      end
   end

   // Counter, pending and sticky error state
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_r[i] <= 2'd0;
         end
         pending_r <= 32'd0;
         sb_err_r  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_r[i]     <= cnt_nxt_s[i];
            pending_r[i] <= (cnt_nxt_s[i] != 2'd0);
         end
         sb_err_r <= sb_err_r | err_s;
      end
   end

   assign pending = pending_r;
   assign sb_err  = sb_err_r;

`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles_r;

   // Saturating count of stalled cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_r <= 32'd0;
      end else if (stall && (stall_cycles_r != 32'hFFFF_FFFF)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign stall_cycles = stall_cycles_r;
`endif

   scoreboard_checker u_chk (
      .clk   (clk),
      .rst   (rst),
      .issue (issue),
      .stall (stall)
   );

endmodule
